// File: rtl/ram_to_axis_reader.sv
// ram_to_axis_reader
//    Reads a packet of ceil(len/DAT_BYTS) consecutive words from a fixed-latency
//    RAM and streams them out as AXI-stream beats with sop/eop/mod/ctl sideband.
//    Reads are credit-limited so that every word returned by the RAM always has
//    a free slot in the output FIFO, whatever the downstream back-pressure.
//
// Ports
//    i_clk, i_rst_n              clock, asynchronous active-low reset
//    i_start, i_addr, i_len,     command strobe, first word address, length in
//    i_ctl                       bytes, sideband copied onto every beat
//    o_busy, o_done              command active / one-cycle completion pulse
//    o_ram_*, i_ram_q            RAM read port (write side tied off)
//    o_val, o_sop, o_eop, o_err, AXI-stream source
//    o_ctl, o_dat, o_mod, i_rdy
//
// state | meaning
// IDLE  | waiting for i_start
// READ  | issuing one read per cycle while credit is available
// DRAIN | all reads issued, waiting for the eop beat to leave
module ram_to_axis_reader #(
   parameter int DAT_BYTS  = 8,
   parameter int RAM_DEPTH = 512,
   parameter int RD_LAT    = 2,
   parameter int CTL_BITS  = 8,
   parameter int MOD_BITS  = $clog2(DAT_BYTS),
   localparam int DAT_BITS = DAT_BYTS * 8,
   localparam int AW       = $clog2(RAM_DEPTH)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic [AW-1:0]       i_addr,
   input  logic [15:0]         i_len,
   input  logic [CTL_BITS-1:0] i_ctl,
   output logic                o_busy,
   output logic                o_done,
   output logic [AW-1:0]       o_ram_a,
   output logic                o_ram_en,
   output logic                o_ram_re,
   output logic                o_ram_we,
   output logic [DAT_BITS-1:0] o_ram_d,
   input  logic [DAT_BITS-1:0] i_ram_q,
   output logic                o_val,
   output logic                o_sop,
   output logic                o_eop,
   output logic                o_err,
   output logic [CTL_BITS-1:0] o_ctl,
   output logic [DAT_BITS-1:0] o_dat,
   output logic [MOD_BITS-1:0] o_mod,
   input  logic                i_rdy
);

   localparam int FD = RD_LAT + 2;
   localparam int PW = (FD > 1) ? $clog2(FD) : 1;
   localparam int CW = $clog2(FD + 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t              state;
   logic [AW-1:0]       ra;
   logic [15:0]         rk;
   logic [15:0]         nw;
   logic [15:0]         ok;
   logic [MOD_BITS-1:0] mod_r;
   logic [CTL_BITS-1:0] ctl_r;
   logic                done_r;
   logic                err_r;
   logic [RD_LAT-1:0]   vld;
   logic [CW-1:0]       inflight;
   logic [CW-1:0]       count;
   logic [PW-1:0]       wp;
   logic [PW-1:0]       rp;
   logic [DAT_BITS-1:0] mem [FD];

   logic [15:0] mod_calc;
   logic [15:0] nw_calc;
   logic        credit;
   logic        issue;
   logic        cap;
   logic        pop;
   logic        is_eop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
   endfunction

   assign mod_calc = i_len % 16'(DAT_BYTS);
   assign nw_calc  = i_len / 16'(DAT_BYTS) + 16'(mod_calc != 16'd0);

   // Reads still in the RAM pipeline already own a FIFO slot.
   assign credit = ({1'b0, inflight} + {1'b0, count}) < (CW + 1)'(FD);
   assign issue  = (state == READ) && credit;
   assign cap    = vld[RD_LAT-1];
   assign pop    = o_val && i_rdy;
   assign is_eop = (ok == nw - 16'd1);

   assign o_ram_a  = issue ? ra : '0;
   assign o_ram_en = issue;
   assign o_ram_re = issue;
   assign o_ram_we = 1'b0;
   assign o_ram_d  = '0;

   // Sideband is gated by o_val so an empty FIFO (including reset) shows all zeros.
   assign o_val  = (count != '0);
   assign o_dat  = o_val ? mem[rp] : '0;
   assign o_sop  = o_val && (ok == 16'd0);
   assign o_eop  = o_val && is_eop;
   assign o_mod  = o_eop ? mod_r : '0;
   assign o_ctl  = o_val ? ctl_r : '0;
   assign o_err  = err_r;
   assign o_done = done_r;
   assign o_busy = (state != IDLE);

   always_ff @(posedge i_clk) begin
      if (cap) mem[wp] <= i_ram_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         ra       <= '0;
         rk       <= '0;
         nw       <= '0;
         ok       <= '0;
         mod_r    <= '0;
         ctl_r    <= '0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         vld      <= '0;
         inflight <= '0;
         count    <= '0;
         wp       <= '0;
         rp       <= '0;
      end else begin
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         vld[0]   <= issue;
         for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
         inflight <= inflight + CW'(issue) - CW'(cap);
         count    <= count + CW'(cap) - CW'(pop);
         if (cap) wp <= ptr_next(wp);
         if (pop) begin
            rp <= ptr_next(rp);
            ok <= ok + 16'd1;
         end
         case (state)
            IDLE: begin
               if (i_start) begin
                  if (i_len == 16'd0) begin
                     done_r <= 1'b1;
                     err_r  <= 1'b1;
                  end else begin
                     ra    <= i_addr;
                     rk    <= '0;
                     nw    <= nw_calc;
                     mod_r <= MOD_BITS'(mod_calc);
                     ctl_r <= i_ctl;
                     ok    <= '0;
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (issue) begin
                  ra <= (ra == AW'(RAM_DEPTH - 1)) ? '0 : ra + AW'(1);
                  rk <= rk + 16'd1;
                  if (rk == nw - 16'd1) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && is_eop) begin
                  state  <= IDLE;
                  done_r <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
